// File: rtl/intf_write_buffer_pkg.sv
// rtl/intf_write_buffer_pkg.sv - shared widths, default entry layout and saturating increment
package intf_write_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_CH   = 2;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_CNT_W  = 16;

  // Channel-index width; N_CH is at least 2, so this is never zero.
  function automatic int ch_width(input int n_ch);
    return (n_ch < 2) ? 1 : $clog2(n_ch);
  endfunction

  // Occupancy width, wide enough to hold the value DEPTH itself.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CH_W  = ch_width(DEF_N_CH);
  localparam int LVL_W = lvl_width(DEF_DEPTH);

  // Entry layout for the default configuration. A parameterised instance
  // declares the same {data, ch} layout locally using its own widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [CH_W-1:0]       ch;
  } entry_t;

  // Increment that sticks at 2^w-1; counters up to 32 bits wide.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] maxv;
    maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= maxv) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/intf_write_buffer_if.sv
// rtl/intf_write_buffer_if.sv - writer/consumer bundle of the write buffer with master/slave modports
interface intf_write_buffer_if
  import intf_write_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);

  localparam int CW = ch_width(N_CH);
  localparam int LW = lvl_width(DEPTH);

  logic                   enable;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CW-1:0]          out_ch;
  logic [LW-1:0]          level;
  logic                   full;
  logic                   empty;
  logic [CNT_W-1:0]       drop_cnt;

  // Producer/consumer side
  modport master (
    output enable, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch, level, full, empty, drop_cnt
  );

  // Buffer side
  modport slave (
    input  enable, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch, level, full, empty, drop_cnt
  );

endinterface

// File: rtl/intf_write_buffer_fifo.sv
// rtl/intf_write_buffer_fifo.sv - DEPTH-entry storage with push/pop, level, full and empty
module intf_write_fifo
  import intf_write_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        pop,
  output logic [WIDTH-1:0]            rdata,
  output logic [lvl_width(DEPTH)-1:0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot that a same-cycle push into a full FIFO needs.
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is not reset; clearing the pointers and level discards it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/intf_write_buffer.sv
// rtl/intf_write_buffer.sv - round-robin write arbiter, ready logic and drop counter in front of a FIFO (trace: INTF_WRITE_TRACE_EN)
module intf_write_buffer
  import intf_write_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 2,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  intf_write_buffer_if.slave bus
);

  localparam int CW = ch_width(N_CH);
  localparam int LW = lvl_width(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CW-1:0]     ch;
  } ent_t;

  logic [CW-1:0]    rr_ptr;
  logic [CW-1:0]    grant;
  logic             grant_vld;
  logic             can_accept;
  logic             transfer;
  logic             push;
  logic             drop;
  logic             pop;
  ent_t             wr_ent;
  ent_t             rd_ent;
  logic [LW-1:0]    fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] drop_cnt;

  // Round-robin scan: first valid channel at or after rr_ptr, wrapping at N_CH.
  always_comb begin
    logic [CW-1:0] idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      if (!grant_vld && bus.in_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
      idx = (idx == CW'(N_CH - 1)) ? '0 : idx + CW'(1);
    end
  end

  // Disabled writes are always taken (and dropped); enabled ones need room,
  // where a pop on this edge counts as room.
  assign can_accept = !bus.enable | !fifo_full | (!fifo_empty & bus.out_ready);
  assign transfer   = !rst & grant_vld & can_accept;
  assign push       = transfer & bus.enable;
  assign drop       = transfer & !bus.enable;
  assign pop        = !fifo_empty & bus.out_ready;

  assign wr_ent.data = bus.in_data[int'(grant)*DATA_W +: DATA_W];
  assign wr_ent.ch   = grant;

  // Ready goes only to the granted channel; the grant depends only on
  // in_valid, so a held request keeps its ready until it transfers.
  always_comb begin
    bus.in_ready = '0;
    if (transfer) bus.in_ready[grant] = 1'b1;
  end

  // Next scan starts just past the channel that last transferred.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (transfer) begin
      rr_ptr <= (grant == CW'(N_CH - 1)) ? '0 : grant + CW'(1);
    end
  end

  // Count writes discarded while disabled, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop) begin
      drop_cnt <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
    end
  end

  intf_write_fifo #(
    .WIDTH ($bits(ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (rd_ent),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = !fifo_empty;
  assign bus.out_data  = rd_ent.data;
  assign bus.out_ch    = rd_ent.ch;
  assign bus.level     = fifo_level;
  assign bus.full      = fifo_full;
  assign bus.empty     = fifo_empty;
  assign bus.drop_cnt  = drop_cnt;

`ifdef INTF_WRITE_TRACE_EN
  // Log every transfer and every pop as it happens on the clock edge.
  always @(posedge clk) begin
    if (!rst) begin
      if (transfer)
        $display("%0t write ch=%0d data=%h %s", $time, grant, wr_ent.data,
                 bus.enable ? "accepted" : "dropped");
      if (pop)
        $display("%0t pop ch=%0d data=%h", $time, rd_ent.ch, rd_ent.data);
    end
  end
`else
`endif

endmodule

// File: tb/tb_intf_write_buffer.sv
// tb/tb_intf_write_buffer.sv - table-driven bench for intf_write_buffer
module tb_intf_write_buffer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  intf_write_buffer_if #(.DATA_W(8), .N_CH(2), .DEPTH(4), .CNT_W(16)) bus ();
  intf_write_buffer_if #(.DATA_W(8), .N_CH(2), .DEPTH(4), .CNT_W(2))  bus2 ();

  intf_write_buffer #(.DATA_W(8), .N_CH(2), .DEPTH(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  intf_write_buffer #(.DATA_W(8), .N_CH(2), .DEPTH(4), .CNT_W(2)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  typedef struct {
    logic        en;
    logic [1:0]  vld;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        ordy;
    logic [1:0]  exp_rdy;
    logic        exp_ov;
    logic [7:0]  exp_data;
    logic        exp_ch;
    logic [2:0]  exp_lvl;
    logic [15:0] exp_drop;
  } vec_t;

  vec_t vt[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic en, logic [1:0] vld, logic [7:0] d0, logic [7:0] d1,
                              logic ordy, logic [1:0] rdy, logic ov, logic [7:0] data,
                              logic ch, logic [2:0] lvl, logic [15:0] drp);
    vec_t v;
    v.en = en; v.vld = vld; v.d0 = d0; v.d1 = d1; v.ordy = ordy;
    v.exp_rdy = rdy; v.exp_ov = ov; v.exp_data = data; v.exp_ch = ch;
    v.exp_lvl = lvl; v.exp_drop = drp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic en, input logic [1:0] vld, input logic [7:0] d0,
                       input logic [7:0] d1, input logic ordy);
    bus.enable    = en;
    bus.in_valid  = vld;
    bus.in_data   = {d1, d0};
    bus.out_ready = ordy;
  endtask

  initial begin
    // Single write, then alternating grants with a draining consumer
    vt.push_back(mk(1, 2'b01, 8'h11, 8'h00, 0, 2'b01, 1, 8'h11, 0, 3'd1, 16'd0));
    vt.push_back(mk(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 3'd0, 16'd0));
    vt.push_back(mk(1, 2'b11, 8'h20, 8'h21, 1, 2'b10, 1, 8'h21, 1, 3'd1, 16'd0));
    vt.push_back(mk(1, 2'b11, 8'h22, 8'h23, 1, 2'b01, 1, 8'h22, 0, 3'd1, 16'd0));
    vt.push_back(mk(1, 2'b11, 8'h24, 8'h25, 1, 2'b10, 1, 8'h25, 1, 3'd1, 16'd0));
    vt.push_back(mk(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 3'd0, 16'd0));
    // Disabled writes on ch1 are accepted and counted, FIFO stays empty
    for (int k = 0; k < 5; k++)
      vt.push_back(mk(0, 2'b10, 8'h00, 8'(8'h30 + k), 0, 2'b10, 0, 8'h00, 0, 3'd0, 16'(k + 1)));
    // Fill to DEPTH with consumer stalled
    for (int k = 0; k < 4; k++)
      vt.push_back(mk(1, 2'b01, 8'(8'h40 + k), 8'h00, 0, 2'b01, 1, 8'h40, 0, 3'(k + 1), 16'd5));
    // Disabled write while full still gets ready and is dropped
    vt.push_back(mk(0, 2'b01, 8'h99, 8'h00, 0, 2'b01, 1, 8'h40, 0, 3'd4, 16'd6));
    // Enabled write while full and stalled is held off
    vt.push_back(mk(1, 2'b01, 8'h44, 8'h00, 0, 2'b00, 1, 8'h40, 0, 3'd4, 16'd6));
    // Push and pop together while full: level stays 4
    vt.push_back(mk(1, 2'b01, 8'h44, 8'h00, 1, 2'b01, 1, 8'h41, 0, 3'd4, 16'd6));
    // Drain in order
    vt.push_back(mk(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h42, 0, 3'd3, 16'd6));
    vt.push_back(mk(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h43, 0, 3'd2, 16'd6));
    vt.push_back(mk(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 1, 8'h44, 0, 3'd1, 16'd6));
    vt.push_back(mk(1, 2'b00, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 0, 3'd0, 16'd6));

    rst = 1'b1;
    drive(1, 2'b11, 8'hAA, 8'hBB, 1);
    bus2.enable = 1'b0; bus2.in_valid = 2'b00; bus2.in_data = '0; bus2.out_ready = 1'b0;
    #2;
    chk("reset in_ready", 32'(bus.in_ready), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset empty", 32'(bus.empty), 1);
    chk("reset full", 32'(bus.full), 0);
    chk("reset level", 32'(bus.level), 0);
    chk("reset drop_cnt", 32'(bus.drop_cnt), 0);

    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 2'b00, 8'h00, 8'h00, 0);

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].vld, vt[i].d0, vt[i].d1, vt[i].ordy);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vt[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].exp_ov));
      if (vt[i].exp_ov) begin
        chk($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vt[i].exp_data));
        chk($sformatf("v%0d out_ch", i), 32'(bus.out_ch), 32'(vt[i].exp_ch));
      end
      chk($sformatf("v%0d level", i), 32'(bus.level), 32'(vt[i].exp_lvl));
      chk($sformatf("v%0d full", i), 32'(bus.full), 32'(vt[i].exp_lvl == 3'd4));
      chk($sformatf("v%0d empty", i), 32'(bus.empty), 32'(vt[i].exp_lvl == 3'd0));
      chk($sformatf("v%0d drop_cnt", i), 32'(bus.drop_cnt), 32'(vt[i].exp_drop));
    end

    // Mid-stream reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 2'b01, 8'(8'h50 + k), 8'h00, 0);
      @(posedge clk); #1;
    end
    chk("pre-reset level", 32'(bus.level), 3);
    drive(1, 2'b01, 8'h53, 8'h00, 0);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 0);
    chk("async rst level", 32'(bus.level), 0);
    chk("async rst empty", 32'(bus.empty), 1);
    chk("async rst drop_cnt", 32'(bus.drop_cnt), 0);
    chk("async rst in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 2'b10, 8'h00, 8'h60, 0);
    #1;
    chk("post-rst in_ready", 32'(bus.in_ready), 32'(2'b10));
    @(posedge clk); #1;
    chk("post-rst out_valid", 32'(bus.out_valid), 1);
    chk("post-rst out_data", 32'(bus.out_data), 32'h60);
    chk("post-rst out_ch", 32'(bus.out_ch), 1);
    chk("post-rst level", 32'(bus.level), 1);
    drive(1, 2'b00, 8'h00, 8'h00, 0);

    // Two-bit drop counter saturates at 3
    bus2.enable = 1'b0; bus2.in_valid = 2'b01; bus2.in_data = 16'h0077;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("sat%0d in_ready", k), 32'(bus2.in_ready), 32'(2'b01));
      @(posedge clk); #1;
      chk($sformatf("sat%0d drop_cnt", k), 32'(bus2.drop_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
      chk($sformatf("sat%0d empty", k), 32'(bus2.empty), 1);
    end
    bus2.in_valid = 2'b00;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/intf_write_buffer.md
Name: intf_write_buffer

Overview:
- Parametrised, clocked successor to the enable-gated interface write task.
- N_CH independent writers with valid/ready handshakes feed a round-robin arbiter; at most one write is accepted per cycle.
- Accepted writes go into a DEPTH-entry FIFO when enabled and are dropped and counted when disabled.
- Sits between testbench/driver-side producers and one downstream consumer; the consumer sees each data word tagged with its source channel.

Parameters:
- DATA_W, 8, data width per write
- N_CH, 2, number of writer channels (>=2)
- DEPTH, 4, FIFO entries (power of 2, >=2)
- CNT_W, 16, width of the drop counter

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous reset, active-high
- enable  input  1  write enable, sampled at the clock edge
- in_valid  input  N_CH  per-channel write request
- in_data  input  N_CH*DATA_W  packed write data; channel i occupies bits [i*DATA_W +: DATA_W]
- in_ready  output  N_CH  per-channel accept (one-hot or zero)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_data  output  DATA_W  head data
- out_ch  output  $clog2(N_CH)  source channel of head
- level  output  $clog2(DEPTH+1)  occupancy
- full  output  1  level==DEPTH
- empty  output  1  level==0
- drop_cnt  output  CNT_W  writes discarded while enable=0

Behaviour:
- Reset (async, rst=1):
  - pointers, level and rr_ptr cleared to 0; drop_cnt cleared to 0.
  - out_valid=0, empty=1, full=0, in_ready=0.
  - Any FIFO contents are discarded, including on a mid-operation reset.
- Arbitration:
  - Each cycle, grant g is the first channel i with in_valid[i]=1, scanning from rr_ptr upward modulo N_CH.
  - No valid channel means no grant.
- Ready rule (combinational):
  - in_ready[g] = !enable | !full | (out_valid & out_ready).
  - All non-granted channels have in_ready=0.
  - A write transfers when in_valid & in_ready on the same rising edge.
- rr_ptr: on a transfer, rr_ptr <= (g+1) mod N_CH; otherwise unchanged.
- Enabled transfer: {in_data[g], g} is pushed into the FIFO.
- Disabled transfer:
  - Data is discarded and drop_cnt increments by 1.
  - drop_cnt saturates at 2^CNT_W-1.
  - FIFO state is unaffected.
- Output:
  - out_valid = !empty; out_data/out_ch show the head entry.
  - Pop occurs when out_valid & out_ready.
  - The FIFO drains regardless of enable.
- Latency: a word pushed at edge N is visible at out_valid/out_data after edge N. There is no same-cycle bypass while empty.
- Boundary conditions:
  - Full with simultaneous pop: push is accepted, level stays DEPTH.
  - Empty with simultaneous push: level becomes 1; no pop that cycle.
  - Pointers wrap modulo DEPTH.
  - level changes by +1, -1 or 0 per cycle.
  - enable toggling mid-stream only affects writes transferring on that edge.
- Handshake obligation: producers hold in_valid and in_data stable until transfer. The block never deasserts a granted in_ready because of in_valid on another channel.

Optional Feature:
- Macro: INTF_WRITE_TRACE_EN.
- Defined: on every transfer, $display reports time, channel, data and accepted/dropped. On every pop, it reports time, channel and data.
- Undefined: no messages; RTL function is identical.

Decomposition:
- Package intf_write_pkg holds:
  - the helper localparams CH_W=$clog2(N_CH) and LVL_W=$clog2(DEPTH+1);
  - the parametrised entry struct {data, ch};
  - a saturating-increment function.
- Sub-module intf_write_fifo: the DEPTH x entry storage with push/pop, level, full and empty. It contains no arbitration logic.
- The top level holds the arbiter, ready logic and drop counter.

Test Plan:
1. Reset then enable=1; ch0 writes 8'h11 -> out_valid rises the following cycle, out_data=8'h11, out_ch=0, level=1.
2. ch0 and ch1 both valid continuously with out_ready=1 -> grants alternate 0,1,0,1 and the output channel sequence matches.
3. enable=0; ch1 writes 5 words -> in_ready=1 each cycle, drop_cnt=5, empty stays 1.
4. out_ready=0; 4 writes -> full=1, in_ready=0. Then out_ready=1 with a pending write -> push and pop in the same cycle, level stays 4, order preserved.
5. Assert rst mid-stream with level=3 -> outputs clear immediately (before the next clk edge), level=0, drop_cnt=0. First write after release appears with the correct data.
6. With CNT_W=2 and 6 disabled writes -> drop_cnt saturates at 3.
